// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - data-cache line geometry shared across the core
package ariane_pkg;

    localparam int unsigned DCACHE_TAG_WIDTH      = 8;
    localparam int unsigned DCACHE_LINE_WIDTH     = 32;
    localparam int unsigned DCACHE_LINE_ECC_WIDTH = 7;

endpackage

// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - core configuration slice used by the data-cache blocks
package config_pkg;

    typedef struct packed {
        bit DCacheEccScrub;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{DCacheEccScrub: 1'b1};

endpackage

// File: rtl/std_cache_pkg.sv
// rtl/std_cache_pkg.sv - cache line types, ECC status, scrub FSM states and Hsiao matrix
package std_cache_pkg;

    localparam int unsigned CL_TAG_W  = ariane_pkg::DCACHE_TAG_WIDTH;
    localparam int unsigned CL_DATA_W = ariane_pkg::DCACHE_LINE_WIDTH;
    localparam int unsigned CL_ECC_W  = ariane_pkg::DCACHE_LINE_ECC_WIDTH;
    localparam int unsigned CL_WAYS   = 8;

    typedef enum logic [1:0] {
        ECC_NONE   = 2'b00,
        ECC_CORR   = 2'b01,
        ECC_UNCORR = 2'b10
    } ecc_err_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SCRUB = 1'b1
    } scrub_state_e;

    typedef struct packed {
        logic [CL_TAG_W-1:0]  tag;
        logic [CL_DATA_W-1:0] data;
        logic                 valid;
        logic                 dirty;
    } cache_line_t;

    typedef struct packed {
        logic [CL_TAG_W-1:0]  tag;
        logic [CL_DATA_W-1:0] data;
        logic [CL_ECC_W-1:0]  ecc;
        logic                 valid;
        logic                 dirty;
    } cache_line_ECC_t;

    typedef struct packed {
        logic [CL_TAG_W-1:0]  tag;
        logic [CL_DATA_W-1:0] data;
        logic [CL_ECC_W-1:0]  ecc;
        logic [CL_WAYS-1:0]   vldrty;
    } cl_be_ECC_t;

    // Data columns are the weight-3 check patterns taken in ascending numeric order.
    function automatic logic [CL_DATA_W-1:0][CL_ECC_W-1:0] hsiao_cols();
        logic [CL_DATA_W-1:0][CL_ECC_W-1:0] cols;
        logic [CL_ECC_W-1:0]                v;
        int unsigned                        n;
        cols = '0;
        n    = 0;
        for (int unsigned k = 0; k < (32'd1 << CL_ECC_W); k++) begin
            v = k[CL_ECC_W-1:0];
            if ($countones(v) == 3 && n < CL_DATA_W) begin
                cols[n] = v;
                n++;
            end
        end
        return cols;
    endfunction

    function automatic logic [CL_ECC_W-1:0][CL_DATA_W-1:0] hsiao_rows(
        input logic [CL_DATA_W-1:0][CL_ECC_W-1:0] cols
    );
        logic [CL_ECC_W-1:0][CL_DATA_W-1:0] rows;
        rows = '0;
        for (int j = 0; j < CL_ECC_W; j++) begin
            for (int i = 0; i < CL_DATA_W; i++) begin
                rows[j][i] = cols[i][j];
            end
        end
        return rows;
    endfunction

    localparam logic [CL_DATA_W-1:0][CL_ECC_W-1:0] HSIAO_COLS = hsiao_cols();
    localparam logic [CL_ECC_W-1:0][CL_DATA_W-1:0] HSIAO_ROWS = hsiao_rows(HSIAO_COLS);

endpackage

// File: rtl/hsiao_ecc_dec.sv
// rtl/hsiao_ecc_dec.sv - Hsiao SECDED decoder: corrects one bit, flags two-bit errors
module hsiao_ecc_dec
    import std_cache_pkg::*;
(
    input  logic [CL_DATA_W-1:0] data_i,
    input  logic [CL_ECC_W-1:0]  ecc_i,
    output logic [CL_DATA_W-1:0] data_o,
    output ecc_err_e             err_o
);

    logic [CL_ECC_W-1:0]  syn;
    logic [CL_DATA_W-1:0] flip;

    always_comb begin
        syn = ecc_i;
        for (int j = 0; j < CL_ECC_W; j++) begin
            syn[j] = syn[j] ^ (^(data_i & HSIAO_ROWS[j]));
        end
        flip = '0;
        for (int i = 0; i < CL_DATA_W; i++) begin
            flip[i] = (syn == HSIAO_COLS[i]);
        end
        data_o = data_i ^ flip;
        // Odd syndrome is a single error only if it names a data column or a lone check bit.
        if (syn == '0) begin
            err_o = ECC_NONE;
        end else if ((^syn) && ((|flip) || ((syn & (syn - 1'b1)) == '0))) begin
            err_o = ECC_CORR;
        end else begin
            err_o = ECC_UNCORR;
        end
    end

endmodule

// File: rtl/hsiao_ecc_enc.sv
// rtl/hsiao_ecc_enc.sv - Hsiao SECDED check-bit generator for one cache line
module hsiao_ecc_enc
    import std_cache_pkg::*;
(
    input  logic [CL_DATA_W-1:0] data_i,
    output logic [CL_ECC_W-1:0]  ecc_o
);

    always_comb begin
        ecc_o = '0;
        for (int j = 0; j < CL_ECC_W; j++) begin
            ecc_o[j] = ^(data_i & HSIAO_ROWS[j]);
        end
    end

endmodule

// File: rtl/dcache_ecc_scrub.sv
// rtl/dcache_ecc_scrub.sv - per-way ECC correction on SRAM reads with single-way write-back scrub
module dcache_ecc_scrub
    import std_cache_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg          = config_pkg::cva6_cfg_empty,
    parameter int unsigned           DCACHE_SET_ASSOC = 8,
    parameter int unsigned           ADDR_WIDTH       = 64,
    parameter int unsigned           CNT_WIDTH        = 16
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   rd_valid_i,
    input  logic [ADDR_WIDTH-1:0]                  rd_addr_i,
    input  cache_line_ECC_t [DCACHE_SET_ASSOC-1:0] rdata_i,
    output cache_line_t [DCACHE_SET_ASSOC-1:0]     rdata_o,
    output logic [DCACHE_SET_ASSOC-1:0]            scrub_req_o,
    input  logic                                   scrub_gnt_i,
    output logic [ADDR_WIDTH-1:0]                  scrub_addr_o,
    output cache_line_ECC_t                        scrub_wdata_o,
    output cl_be_ECC_t                             scrub_be_o,
    output logic                                   scrub_we_o,
    output logic                                   busy_o,
    output logic                                   corr_err_o,
    output logic                                   uncorr_err_o,
    output logic [CNT_WIDTH-1:0]                   corr_cnt_o,
    output logic [CNT_WIDTH-1:0]                   uncorr_cnt_o,
    output logic [CNT_WIDTH-1:0]                   drop_cnt_o
);

    ecc_err_e                    way_err  [DCACHE_SET_ASSOC];
    logic [CL_DATA_W-1:0]        way_data [DCACHE_SET_ASSOC];
    logic [DCACHE_SET_ASSOC-1:0] corr_vec;
    logic [DCACHE_SET_ASSOC-1:0] uncorr_vec;

    for (genvar w = 0; w < DCACHE_SET_ASSOC; w++) begin : g_way
        hsiao_ecc_dec u_dec (
            .data_i (rdata_i[w].data),
            .ecc_i  (rdata_i[w].ecc),
            .data_o (way_data[w]),
            .err_o  (way_err[w])
        );
        assign rdata_o[w] = '{tag:   rdata_i[w].tag,
                              data:  way_data[w],
                              valid: rdata_i[w].valid,
                              dirty: rdata_i[w].dirty};
        assign corr_vec[w]   = rd_valid_i && (way_err[w] == ECC_CORR);
        assign uncorr_vec[w] = rd_valid_i && (way_err[w] == ECC_UNCORR);
    end

    logic [DCACHE_SET_ASSOC-1:0] pick_oh;
    cache_line_t                 pick_line;

    always_comb begin
        pick_oh   = '0;
        pick_line = '0;
        for (int w = int'(DCACHE_SET_ASSOC) - 1; w >= 0; w--) begin
            if (corr_vec[w]) begin
                pick_oh    = '0;
                pick_oh[w] = 1'b1;
                pick_line  = rdata_o[w];
            end
        end
    end

    logic any_corr, any_uncorr, multi_corr, drop_ev;
    scrub_state_e state_q;

    assign any_corr   = |corr_vec;
    assign any_uncorr = |uncorr_vec;
    assign multi_corr = |(corr_vec & (corr_vec - 1'b1));
    // Any correctable read that cannot claim the single write-back slot is counted as dropped.
    assign drop_ev    = any_corr && (state_q == SCRUB || multi_corr || !CVA6Cfg.DCacheEccScrub);

    logic [DCACHE_SET_ASSOC-1:0] req_q;
    logic                        we_q, busy_q, corr_err_q, uncorr_err_q;
    logic [ADDR_WIDTH-1:0]       addr_q;
    cache_line_t                 line_q;
    logic [CNT_WIDTH-1:0]        corr_cnt_q, uncorr_cnt_q, drop_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            req_q        <= '0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            addr_q       <= '0;
            line_q       <= '0;
            corr_err_q   <= 1'b0;
            uncorr_err_q <= 1'b0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            corr_err_q   <= any_corr;
            uncorr_err_q <= any_uncorr;
            if (any_corr && corr_cnt_q != '1) corr_cnt_q <= corr_cnt_q + 1'b1;
            if (any_uncorr && uncorr_cnt_q != '1) uncorr_cnt_q <= uncorr_cnt_q + 1'b1;
            if (drop_ev && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (any_corr && CVA6Cfg.DCacheEccScrub) begin
                        state_q <= SCRUB;
                        req_q   <= pick_oh;
                        we_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        addr_q  <= rd_addr_i;
                        line_q  <= pick_line;
                    end
                end
                SCRUB: begin
                    if (scrub_gnt_i) begin
                        state_q <= IDLE;
                        req_q   <= '0;
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    logic [CL_ECC_W-1:0] wb_ecc;

    hsiao_ecc_enc u_enc (
        .data_i (line_q.data),
        .ecc_o  (wb_ecc)
    );

    assign scrub_wdata_o = '{tag:   line_q.tag,
                             data:  line_q.data,
                             ecc:   wb_ecc,
                             valid: line_q.valid,
                             dirty: line_q.dirty};

    always_comb begin
        scrub_be_o = '0;
        if (busy_q) begin
            scrub_be_o.tag  = '1;
            scrub_be_o.data = '1;
            scrub_be_o.ecc  = '1;
        end
    end

    assign scrub_req_o  = req_q;
    assign scrub_we_o   = we_q;
    assign busy_o       = busy_q;
    assign scrub_addr_o = addr_q;
    assign corr_err_o   = corr_err_q;
    assign uncorr_err_o = uncorr_err_q;
    assign corr_cnt_o   = corr_cnt_q;
    assign uncorr_cnt_o = uncorr_cnt_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: doc/dcache_ecc_scrub.md
DCACHE_ECC_SCRUB -- requirements
Module: dcache_ecc_scrub

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration.
- DCACHE_SET_ASSOC, 8, number of ways.
- ADDR_WIDTH, 64, SRAM index address width.
- CNT_WIDTH, 16, width of the error counters.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk_i, in, 1, clock.
- rst_ni, in, 1, asynchronous active-low reset.
- rd_valid_i, in, 1, rdata_i is valid this cycle (SRAM read response, one cycle after request).
- rd_addr_i, in, ADDR_WIDTH, index address of that read.
- rdata_i, in, DCACHE_SET_ASSOC x cache_line_ECC_t, raw ECC-protected lines.
- rdata_o, out, DCACHE_SET_ASSOC x cache_line_t, decoded and corrected lines.
- scrub_req_o, out, DCACHE_SET_ASSOC, one-hot way write-back request.
- scrub_gnt_i, in, 1, grant from the SRAM arbiter.
- scrub_addr_o, out, ADDR_WIDTH, write-back index.
- scrub_wdata_o, out, cache_line_ECC_t, re-encoded corrected line.
- scrub_be_o, out, cl_be_ECC_t, write-back byte enables.
- scrub_we_o, out, 1, write enable.
- busy_o, out, 1, a scrub is pending.
- corr_err_o, out, 1, one-cycle pulse: correctable error seen.
- uncorr_err_o, out, 1, one-cycle pulse: uncorrectable error seen.
- corr_cnt_o, out, CNT_WIDTH, saturating count of correctable events.
- uncorr_cnt_o, out, CNT_WIDTH, saturating count of uncorrectable events.
- drop_cnt_o, out, CNT_WIDTH, saturating count of correctable events not scrubbed.

Function
REQ-003 rdata_o SHALL be combinational from rdata_i: data corrected per way; valid, tag and dirty passed through unchanged.
REQ-004 Per-way error status SHALL be 2 bits: 00 none, 01 correctable, 10 uncorrectable; status SHALL be evaluated only when rd_valid_i=1.
REQ-005 corr_err_o SHALL pulse one cycle after a rd_valid_i cycle with any way at 01; uncorr_err_o likewise for any way at 10; both may pulse in the same cycle.
REQ-006 corr_cnt_o and uncorr_cnt_o SHALL each increment by 1 per qualifying read (not per way), saturating at all-ones.
REQ-007 The FSM SHALL have two states, IDLE and SCRUB.
REQ-008 In IDLE, on rd_valid_i with at least one way at 01, the FSM SHALL capture rd_addr_i, the lowest-indexed correctable way and its corrected line, then enter SCRUB on the next edge.
REQ-009 In SCRUB, the block SHALL drive scrub_req_o one-hot on the captured way, scrub_we_o=1, scrub_be_o all-ones on data, ECC and tag fields with vldrty=0, scrub_addr_o the captured index and scrub_wdata_o the re-encoded line; it SHALL hold all of these stable until scrub_gnt_i.
REQ-010 On scrub_gnt_i in SCRUB, the FSM SHALL return to IDLE on the same edge; scrub_req_o SHALL be 0 the following cycle.
REQ-011 drop_cnt_o SHALL increment when a correctable read occurs while in SCRUB, or when more than one way is correctable in a captured read (extra ways are not scrubbed).
REQ-012 Uncorrectable ways SHALL never be scrubbed.
REQ-013 Outside SCRUB, busy_o, scrub_req_o and scrub_we_o SHALL be 0; busy_o SHALL be 1 exactly in SCRUB.
REQ-014 A scrub_gnt_i received in IDLE SHALL be ignored.

Reset
REQ-015 On rst_ni low, the FSM SHALL enter IDLE asynchronously, all counters SHALL become 0, and all pulses and scrub outputs SHALL become 0; a pending scrub SHALL be abandoned.

Structure
REQ-016 The error-status encoding, the FSM state enum and the cache_line_ECC_t and cl_be_ECC_t types SHALL live in std_cache_pkg; the ECC width SHALL come from ariane_pkg::DCACHE_LINE_ECC_WIDTH.
REQ-017 The block SHALL instantiate one hsiao_ecc_dec per way and one hsiao_ecc_enc for the write-back line, and no other sub-module.

Verification
REQ-018 The bench SHALL cover at least these scenarios:
- Single-bit flip on way 3 data bit 17, rd_valid_i=1, addr 0x40 -> corrected rdata_o same cycle; corr_err_o pulse next cycle; corr_cnt_o=1; scrub_req_o=0b00001000 at addr 0x40; ECC re-encoded.
- scrub_gnt_i withheld for 5 cycles while 2 further correctable reads arrive -> request held stable; drop_cnt_o=2; IDLE after grant.
- Double-bit flip on way 0 -> uncorr_err_o pulse; uncorr_cnt_o=1; no scrub_req_o.
- Ways 1 and 5 correctable in one read -> way 1 scrubbed; drop_cnt_o=1; corr_cnt_o=1.
- Counter preloaded to 0xFFFF plus a correctable read -> stays at 0xFFFF.
- rst_ni asserted in SCRUB -> scrub_req_o=0 immediately; counters 0.
